// File: rtl/gpu_line_sequencer.sv
// Command sequencer in front of the Bresenham line engine: issues one line,
// or a rectangle outline as four segments, with a per-segment watchdog and abort.
module gpu_line_sequencer #(
  parameter int WIDTH_BITS     = 10,
  parameter int HEIGHT_BITS    = 9,
  parameter int CHANNEL_BITS   = 8,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [WIDTH_BITS-1:0]   cmd_x1,
  input  logic [WIDTH_BITS-1:0]   cmd_x2,
  input  logic [HEIGHT_BITS-1:0]  cmd_y1,
  input  logic [HEIGHT_BITS-1:0]  cmd_y2,
  input  logic [CHANNEL_BITS-1:0] cmd_r,
  input  logic [CHANNEL_BITS-1:0] cmd_g,
  input  logic [CHANNEL_BITS-1:0] cmd_b,
  input  logic                    abort,
  output logic [WIDTH_BITS-1:0]   le_x1,
  output logic [WIDTH_BITS-1:0]   le_x2,
  output logic [HEIGHT_BITS-1:0]  le_y1,
  output logic [HEIGHT_BITS-1:0]  le_y2,
  output logic [CHANNEL_BITS-1:0] le_r,
  output logic [CHANNEL_BITS-1:0] le_g,
  output logic [CHANNEL_BITS-1:0] le_b,
  output logic                    le_start,
  input  logic                    le_done,
  input  logic                    le_busy,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              seg_idx
);
  // Handshake: a command transfers on the rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready is combinational from state and abort, cmd_valid must not depend on it.
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_WAIT, S_FIN} state_t;

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                  r_state, w_next;
  logic [WD_W-1:0]         r_wd;
  logic [WIDTH_BITS-1:0]   r_x1, r_x2;
  logic [HEIGHT_BITS-1:0]  r_y1, r_y2;
  logic [CHANNEL_BITS-1:0] r_r, r_g, r_b;
  logic                    r_rect;
  logic [1:0]              r_seg;
  logic                    r_err;
  logic                    w_accept, w_last, w_seg_done, w_timeout, w_abort;
  logic                    w_unused;

  assign w_unused   = le_busy;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_abort    = abort && (r_state != S_IDLE);
  assign w_last     = !r_rect || (r_seg == 2'd3);
  assign w_seg_done = (r_state == S_WAIT) && le_done;
  assign w_timeout  = (r_state == S_WAIT) && !le_done && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_next = S_SETUP;
        S_SETUP: w_next = S_START;
        S_START: w_next = S_WAIT;
        S_WAIT: begin
          if (w_seg_done)     w_next = w_last ? S_FIN : S_SETUP;
          else if (w_timeout) w_next = S_FIN;
        end
        S_FIN:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE) && !abort;
    busy      = (r_state != S_IDLE);
    le_start  = (r_state == S_START) || (r_state == S_WAIT);
    done      = (r_state == S_FIN);
    err       = (r_state == S_FIN) && r_err;
    seg_idx   = r_seg;
  end

  // Watchdog is zero in START and counts every START/WAIT cycle, so it reads k in the k-th WAIT cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_x1   <= '0;
      r_x2   <= '0;
      r_y1   <= '0;
      r_y2   <= '0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
      r_rect <= 1'b0;
      r_seg  <= 2'd0;
      r_err  <= 1'b0;
      r_wd   <= '0;
    end else begin
      if (w_accept) begin
        r_x1   <= cmd_x1;
        r_x2   <= cmd_x2;
        r_y1   <= cmd_y1;
        r_y2   <= cmd_y2;
        r_r    <= cmd_r;
        r_g    <= cmd_g;
        r_b    <= cmd_b;
        r_rect <= cmd_op && (cmd_x1 != cmd_x2) && (cmd_y1 != cmd_y2);
      end
      if ((r_state == S_START) || (r_state == S_WAIT)) r_wd <= r_wd + 1'b1;
      else                                             r_wd <= '0;
      if (w_abort || (r_state == S_FIN)) begin
        r_seg <= 2'd0;
        r_err <= 1'b0;
      end else if (w_seg_done && !w_last) begin
        r_seg <= r_seg + 2'd1;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // A degenerate rectangle is held as a plain line, so only true rectangles walk the corners.
  always_comb begin
    le_x1 = r_x1;
    le_y1 = r_y1;
    le_x2 = r_x2;
    le_y2 = r_y2;
    if (r_rect) begin
      case (r_seg)
        2'd0:    begin le_x1 = r_x1; le_y1 = r_y1; le_x2 = r_x2; le_y2 = r_y1; end
        2'd1:    begin le_x1 = r_x2; le_y1 = r_y1; le_x2 = r_x2; le_y2 = r_y2; end
        2'd2:    begin le_x1 = r_x2; le_y1 = r_y2; le_x2 = r_x1; le_y2 = r_y2; end
        default: begin le_x1 = r_x1; le_y1 = r_y2; le_x2 = r_x1; le_y2 = r_y1; end
      endcase
    end
  end

  assign le_r = r_r;
  assign le_g = r_g;
  assign le_b = r_b;

endmodule

// File: tb/tb_gpu_line_sequencer.sv
// Bench for gpu_line_sequencer: engine model, segment scoreboard, timeout, abort and reset cases.
module tb_gpu_line_sequencer;
  logic       clk = 1'b0;
  logic       n_rst;
  logic       cmd_valid, cmd_ready, cmd_op, abort;
  logic [9:0] cmd_x1, cmd_x2, le_x1, le_x2;
  logic [8:0] cmd_y1, cmd_y2, le_y1, le_y2;
  logic [7:0] cmd_r, cmd_g, cmd_b, le_r, le_g, le_b;
  logic       le_start, le_done, le_busy, busy, done, err;
  logic [1:0] seg_idx;

  logic [63:0] exp_q[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, n_rise = 0, n_done = 0, rise_cyc = 0;
  int eng_lat = 3;
  bit eng_en = 1'b1;
  int eng_cnt = 0;
  bit eng_prev = 1'b0;

  gpu_line_sequencer #(.WIDTH_BITS(10), .HEIGHT_BITS(9), .CHANNEL_BITS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .cmd_y1(cmd_y1), .cmd_y2(cmd_y2),
    .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b), .abort(abort),
    .le_x1(le_x1), .le_x2(le_x2), .le_y1(le_y1), .le_y2(le_y2),
    .le_r(le_r), .le_g(le_g), .le_b(le_b), .le_start(le_start), .le_done(le_done),
    .le_busy(le_busy), .busy(busy), .done(done), .err(err), .seg_idx(seg_idx)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [1:0] s, input logic [9:0] a, input logic [8:0] b,
                                     input logic [9:0] c, input logic [8:0] d, input logic [23:0] col);
    return {s, a, b, c, d, col};
  endfunction

  task automatic push_exp(input logic op, input logic [9:0] x1, input logic [8:0] y1,
                          input logic [9:0] x2, input logic [8:0] y2, input logic [23:0] col);
    if (op && (x1 != x2) && (y1 != y2)) begin
      exp_q.push_back(pk(2'd0, x1, y1, x2, y1, col));
      exp_q.push_back(pk(2'd1, x2, y1, x2, y2, col));
      exp_q.push_back(pk(2'd2, x2, y2, x1, y2, col));
      exp_q.push_back(pk(2'd3, x1, y2, x1, y1, col));
    end else begin
      exp_q.push_back(pk(2'd0, x1, y1, x2, y2, col));
    end
  endtask

  // engine model and scoreboard, both on the falling edge
  always @(negedge clk) begin
    le_done = 1'b0;
    if (!n_rst) begin
      eng_prev = 1'b0;
      eng_cnt  = 0;
    end else begin
      if (done) n_done++;
      if (err) check("err_without_done", done, 1);
      if (le_start && !eng_prev) begin
        n_rise++;
        rise_cyc = cyc;
        eng_cnt  = eng_lat;
        if (exp_q.size() == 0) check("unexpected_segment", 1, 0);
        else check("segment", pk(seg_idx, le_x1, le_y1, le_x2, le_y2, {le_r, le_g, le_b}), exp_q.pop_front());
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0 && eng_en) le_done = 1'b1;
      end
      eng_prev = le_start;
    end
  end

  // driver tasks
  task automatic send_cmd(input logic op, input logic [9:0] x1, input logic [8:0] y1,
                          input logic [9:0] x2, input logic [8:0] y2, input logic [23:0] col);
    bit rdy = 1'b0;
    push_exp(op, x1, y1, x2, y2, col);
    cmd_op = op; cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2;
    {cmd_r, cmd_g, cmd_b} = col;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !rdy; i++) begin
      if (cmd_ready) rdy = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!rdy) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 1'(~op);
    cmd_x1 = 10'($urandom_range(0, 1023)); cmd_x2 = 10'($urandom_range(0, 1023));
    cmd_y1 = 9'($urandom_range(0, 511));   cmd_y2 = 9'($urandom_range(0, 511));
    {cmd_r, cmd_g, cmd_b} = 24'($urandom);
  endtask

  task automatic wait_done(input logic exp_err, output int dcyc);
    bit seen = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done) begin seen = 1'b1; dcyc = cyc; end
      else begin @(posedge clk); #1; end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("err_at_done", err, exp_err);
      check("le_start_at_done", le_start, 0);
      @(posedge clk); #1;
      check("idle_after_done", {busy, done, cmd_ready}, 3'b001);
    end
  endtask

  initial begin
    int n0, d0, rc, dcyc, nseg;
    logic op;
    logic [9:0] x1, x2;
    logic [8:0] y1, y2;
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; abort = 1'b0; le_busy = 1'b0;
    cmd_x1 = '0; cmd_x2 = '0; cmd_y1 = '0; cmd_y2 = '0; cmd_r = '0; cmd_g = '0; cmd_b = '0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {cmd_ready, le_start, busy, done, err, seg_idx}, 7'b1000000);
    check("rst_le", {le_x1, le_y1, le_x2, le_y2, le_r, le_g, le_b}, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ctl", {cmd_ready, le_start, busy, done, err}, 5'b10000);

    // single line with fixed timing
    eng_lat = 3;
    n0 = n_rise;
    send_cmd(1'b0, 10'd2, 9'd3, 10'd6, 9'd3, 24'hFF0080);
    check("line_setup_ep", {le_x1, le_y1, le_x2, le_y2}, {10'd2, 9'd3, 10'd6, 9'd3});
    check("line_setup_ctl", {le_start, busy, cmd_ready}, 3'b010);
    @(posedge clk); #1;
    check("line_start_rise", le_start, 1);
    rc = cyc;
    wait_done(1'b0, dcyc);
    check("line_done_latency", dcyc - rc, eng_lat + 1);
    check("line_rises", n_rise - n0, 1);
    check("line_q_empty", exp_q.size(), 0);

    // rectangle outline
    eng_lat = 2;
    n0 = n_rise; d0 = n_done;
    send_cmd(1'b1, 10'd1, 9'd1, 10'd4, 9'd5, 24'h123456);
    wait_done(1'b0, dcyc);
    check("rect_rises", n_rise - n0, 4);
    check("rect_done_count", n_done - d0, 1);
    check("rect_q_empty", exp_q.size(), 0);

    // degenerate rectangle
    n0 = n_rise;
    send_cmd(1'b1, 10'd5, 9'd2, 10'd5, 9'd9, 24'hA5A5A5);
    wait_done(1'b0, dcyc);
    check("degen_rises", n_rise - n0, 1);

    // watchdog timeout
    eng_en = 1'b0;
    n0 = n_rise;
    send_cmd(1'b0, 10'd7, 9'd7, 10'd100, 9'd50, 24'h00FF00);
    wait_done(1'b1, dcyc);
    check("timeout_latency", dcyc - rise_cyc, 16);
    check("timeout_rises", n_rise - n0, 1);
    eng_en = 1'b1;

    // abort in WAIT of rect segment 1
    eng_lat = 6;
    d0 = n_done;
    send_cmd(1'b1, 10'd3, 9'd2, 10'd8, 9'd7, 24'h0F0F0F);
    for (int i = 0; i < 100 && !(le_start && seg_idx == 2'd1); i++) begin @(posedge clk); #1; end
    check("abort_reach_seg1", {le_start, seg_idx}, 3'b101);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_ctl", {le_start, busy, seg_idx, cmd_ready}, 5'b00000);
    abort = 1'b0;
    #1;
    check("abort_ready", cmd_ready, 1);
    check("abort_pending_segs", exp_q.size(), 2);
    exp_q.delete();
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", n_done - d0, 0);
    eng_lat = 2;
    n0 = n_rise;
    send_cmd(1'b0, 10'd9, 9'd4, 10'd20, 9'd11, 24'hC0FFEE);
    wait_done(1'b0, dcyc);
    check("post_abort_rises", n_rise - n0, 1);

    // random commands
    for (int k = 0; k < 6; k++) begin
      op = 1'($urandom_range(0, 1));
      x1 = 10'($urandom_range(0, 7)); x2 = 10'($urandom_range(0, 7));
      y1 = 9'($urandom_range(0, 7));  y2 = 9'($urandom_range(0, 7));
      nseg = (op && x1 != x2 && y1 != y2) ? 4 : 1;
      eng_lat = $urandom_range(1, 8);
      n0 = n_rise;
      send_cmd(op, x1, y1, x2, y2, 24'($urandom));
      wait_done(1'b0, dcyc);
      check("rand_rises", n_rise - n0, nseg);
    end

    // asynchronous reset mid-command
    eng_lat = 8;
    send_cmd(1'b1, 10'd10, 9'd10, 10'd30, 9'd20, 24'h777777);
    for (int i = 0; i < 20 && !le_start; i++) begin @(posedge clk); #1; end
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst", {le_start, busy, cmd_ready, seg_idx}, 5'b00100);
    exp_q.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("q_final_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gpu_line_sequencer.md
Name: gpu_line_sequencer

Overview:
- Command-level controller in front of the Bresenham line engine (gpu_draw_line).
- Accepts one primitive command: a single line, or a rectangle outline expanded into 4 line segments.
- Drives the engine's endpoint/colour inputs and its level-sensitive start, and detects per-segment completion.
- Provides a one-cycle command done pulse, a watchdog error and a synchronous abort.

Parameters:
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 9, y coordinate width
- CHANNEL_BITS, 8, colour channel width
- TIMEOUT_CYCLES, 2048, max cycles per segment from le_start rise to le_done

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  1  0 = line, 1 = rectangle outline
- cmd_x1, cmd_x2  in  WIDTH_BITS  x endpoints / corners
- cmd_y1, cmd_y2  in  HEIGHT_BITS  y endpoints / corners
- cmd_r, cmd_g, cmd_b  in  CHANNEL_BITS  colour
- abort  in  1  synchronous abort of the current command
- le_x1, le_x2  out  WIDTH_BITS  segment endpoints to the line engine
- le_y1, le_y2  out  HEIGHT_BITS  segment endpoints to the line engine
- le_r, le_g, le_b  out  CHANNEL_BITS  colour to the line engine
- le_start  out  1  line engine start level
- le_done  in  1  line engine done
- le_busy  in  1  line engine busy (status only, not used for control)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command end
- err  out  1  one-cycle pulse coincident with done on timeout
- seg_idx  out  2  current segment index (debug)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (n_rst).
- Reset values:
  - state IDLE
  - cmd_ready=1, busy=0, done=0, err=0, le_start=0, seg_idx=0
  - le_* coordinates and colour = 0
  - watchdog = 0
- Command accept:
  - Handshake completes on cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE) && !abort.
  - All cmd_* fields are latched on accept; later changes are ignored.
  - busy=1 from the cycle after accept until the cycle done pulses (inclusive).
- States:
  - IDLE: wait for accept, then go to SETUP.
  - SETUP: le_* driven with segment[seg_idx]; le_start=0. Guarantees at least one low cycle so the engine sees a rising edge. Next state START.
  - START: le_start=1, watchdog cleared. Next state WAIT.
  - WAIT: le_start held 1; watchdog increments each cycle.
    - le_done==1: le_start=0 next cycle. If this is the last segment, go to FIN; else seg_idx++ and go to SETUP.
    - Watchdog reaches TIMEOUT_CYCLES-1 with no le_done: go to FIN with error flag set.
  - FIN: done=1 for exactly one cycle; err=1 in the same cycle if the error flag is set; le_start=0. Next state IDLE, clearing seg_idx and the error flag.
- Segment expansion (latched corners):
  - Line: one segment (x1,y1)->(x2,y2).
  - Rect: seg0 (x1,y1)->(x2,y1); seg1 (x2,y1)->(x2,y2); seg2 (x2,y2)->(x1,y2); seg3 (x1,y2)->(x1,y1).
  - Degenerate rect (x1==x2 or y1==y2) is issued as the single line segment (x1,y1)->(x2,y2).
- Colour: le_r/g/b = latched colour, constant for the whole command.
- le_done is honoured only in WAIT. le_done seen in SETUP or START is ignored; the engine holds done low during its start-edge cycle.
- abort (any non-IDLE state):
  - Next cycle: state IDLE, le_start=0, busy=0, seg_idx=0.
  - No done and no err pulse.
  - abort in IDLE has no effect, but blocks acceptance that cycle.
- No command queueing: a second cmd_valid while busy stalls (cmd_ready=0).
- Asynchronous reset mid-command forces the reset values immediately; le_start drops asynchronously.

Test Plan:
- Reset → cmd_ready=1, le_start=0, busy=0, done=0 with n_rst asserted and after release.
- Line (2,3)->(6,3), colour (FF,00,80), with engine model → accept at cycle 0; SETUP cycle 1 with le_x1=2, le_y1=3, le_x2=6, le_y2=3; le_start rises cycle 2; exactly one le_start rise; done pulses 1 cycle after le_done is sampled, then busy=0.
- Rect (1,1)-(4,5) → four le_start rising edges with endpoints (1,1)->(4,1), (4,1)->(4,5), (4,5)->(1,5), (1,5)->(1,1); le_start low ≥1 cycle between segments; seg_idx steps 0..3; single done pulse.
- Degenerate rect (5,2)-(5,9) → one segment (5,2)->(5,9); one done pulse.
- Engine never asserts le_done, TIMEOUT_CYCLES=16 → done and err pulse together 16 cycles after le_start rose; le_start=0 at that point; cmd_ready=1 on the next cycle.
- abort asserted in WAIT of rect seg1 → next cycle le_start=0, busy=0, no done; a new line command is then accepted and completes normally.
